ps2_key_sequencer: RTL and testbench
====================================

// Module: ps2_key_sequencer
// PURPOSE
//  Drains the ps2_keyboard receive FIFO through its ready/nextdata_n handshake.
//  Parses the scan-code byte stream (E0 extended and F0 break prefixes) into key events.
//  Hands each event downstream over a valid/ready interface and keeps a key-press
//  counter plus a sticky overflow flag. Sits between ps2_keyboard and display/7-seg logic.
// PARAMETERS
//  CNT_W    8    width of press_cnt; wraps modulo 2^CNT_W
// PORTS
//  clk            in   1  system clock; all logic on posedge
//  rst            in   1  synchronous reset, active-high
//  ps2_clrn       out  1  clear to ps2_keyboard; = ~rst (combinational)
//  ps2_ready      in   1  ps2_keyboard FIFO non-empty
//  ps2_data       in   8  ps2_keyboard FIFO head byte
//  ps2_overflow   in   1  ps2_keyboard FIFO overflow
//  ps2_nextdata_n out  1  active-low pop strobe, exactly one cycle per byte
//  evt_valid      out  1  event register holds an event
//  evt_ready      in   1  downstream accepts event this cycle
//  evt_code       out  8  scan code, prefixes stripped
//  evt_break      out  1  1 = key release (F0 seen), 0 = press
//  evt_ext        out  1  1 = extended key (E0 seen)
//  press_cnt      out  CNT_W  number of press events emitted
//  err_ovf        out  1  sticky, set when ps2_overflow=1
//  err_clr        in   1  clears err_ovf
// BEHAVIOUR
//  Reset (rst=1 at posedge): state=S_IDLE, ps2_nextdata_n=1, evt_valid=0, evt_code=0,
//   evt_break=0, evt_ext=0, press_cnt=0, err_ovf=0, ext/brk prefix flags=0.
//   A pending event or half-parsed prefix is discarded. ps2_keyboard is flushed via ps2_clrn.
//  FSM (one byte per 3 cycles minimum):
//   S_IDLE: if ps2_ready && (!evt_valid || evt_ready): capture ps2_data, parse, -> S_ACK.
//           Otherwise hold (backpressure: no pop while a held event is unconsumed).
//   S_ACK : ps2_nextdata_n=0 for this cycle only; -> S_GAP.
//   S_GAP : ps2_nextdata_n=1; lets ps2_ready/ps2_data refresh; -> S_IDLE.
//  Parse at capture edge:
//   byte F0: brk flag=1, no event.  byte E0: ext flag=1, no event.
//   other byte: load evt_code=byte, evt_break=brk, evt_ext=ext, evt_valid=1; clear both flags.
//   A second E0 or F0 before a code byte just re-sets its flag (idempotent).
//  Handshake: evt_valid drops on the edge where evt_valid&&evt_ready, unless a new event loads
//   on the same edge (evt_valid stays 1, fields replaced). Fields are stable while valid&&!ready.
//  press_cnt increments on the edge a press event (evt_break=0) is loaded. It wraps
//   2^CNT_W-1 -> 0 and does not count break events.
//  err_ovf: set on any cycle ps2_overflow=1; err_clr=1 clears it; set wins if both are 1.
//  Latency: ps2_ready seen in S_IDLE at edge t -> evt_valid=1 after edge t, nextdata_n low
//   during cycle t+1.
// CONFIGURATION
//  TYPEMATIC_FILTER_EN defined: a held-key register {ext,code,held} is kept.
//   A press whose {ext,code} equals the held key while held=1 is consumed from the FIFO (popped
//   as normal) but raises no event and does not change press_cnt.
//   A press of a different key replaces the held key. A break matching the held key clears held.
//   The held register is cleared on reset.
//  Not defined: every press byte, auto-repeat included, emits an event and counts.
// TESTING
//  1 FIFO bytes 1C -> event {ext0,brk0,1C}; press_cnt 0->1; exactly one nextdata_n low pulse.
//  2 bytes F0,1C -> single event {0,1,1C}; press_cnt unchanged; two pops.
//  3 bytes E0,F0,75 -> event {1,1,75}; bytes E0,75 -> {1,0,75}.
//  4 evt_ready=0, bytes 1C,32 queued -> event 1C held stable, nextdata_n stays 1 after first pop;
//    raise evt_ready -> 32 delivered next, no byte lost.
//  5 press_cnt=FF, CNT_W=8, byte 24 -> press_cnt=00. ps2_overflow pulse -> err_ovf=1 until err_clr.
//  6 rst after E0 captured -> flags clear; next byte 75 -> {0,0,75}.
//    With TYPEMATIC_FILTER_EN: 1C,1C,1C -> one event, press_cnt=1.

Source files
------------

// File: rtl/ps2_key_sequencer.sv
// ps2_key_sequencer: drains the ps2_keyboard FIFO, parses E0/F0 prefixes into key events.
// Optional TYPEMATIC_FILTER_EN suppresses auto-repeat presses of the currently held key.
module ps2_key_sequencer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    output logic             ps2_clrn,
    input  logic             ps2_ready,
    input  logic [7:0]       ps2_data,
    input  logic             ps2_overflow,
    output logic             ps2_nextdata_n,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [7:0]       evt_code,
    output logic             evt_break,
    output logic             evt_ext,
    output logic [CNT_W-1:0] press_cnt,
    output logic             err_ovf,
    input  logic             err_clr
);
    typedef enum logic [1:0] {S_IDLE, S_ACK, S_GAP} state_t;
    state_t state, state_nx;
    logic take, is_code, emit, ext_flag, brk_flag;
    assign ps2_clrn = ~rst;
    always_comb begin
        state_nx       = state;
        ps2_nextdata_n = 1'b1;
        take           = 1'b0;
        case (state)
            S_IDLE: begin
                take     = ps2_ready && (!evt_valid || evt_ready);
                state_nx = take ? S_ACK : S_IDLE;
            end
            S_ACK: begin
                ps2_nextdata_n = 1'b0;
                state_nx       = S_GAP;
            end
            default: state_nx = S_IDLE;
        endcase
    end
    always_ff @(posedge clk)
        state <= rst ? S_IDLE : state_nx;
    assign is_code = take && ps2_data != 8'hF0 && ps2_data != 8'hE0;
`ifdef TYPEMATIC_FILTER_EN
    logic       held, held_ext;
    logic [7:0] held_code;
    logic       same_key;
    assign same_key = held && held_ext == ext_flag && held_code == ps2_data;
    assign emit     = is_code && !(same_key && !brk_flag);
    always_ff @(posedge clk)
        if (rst) begin
            held      <= 1'b0;
            held_ext  <= 1'b0;
            held_code <= 8'h00;
        end else if (is_code && !brk_flag) begin
            held      <= 1'b1;
            held_ext  <= ext_flag;
            held_code <= ps2_data;
        end else if (is_code && same_key) begin
            held <= 1'b0;
        end
`else
    assign emit = is_code;
`endif
    always_ff @(posedge clk)
        if (rst) begin
            ext_flag  <= 1'b0;
            brk_flag  <= 1'b0;
            evt_valid <= 1'b0;
            evt_code  <= 8'h00;
            evt_break <= 1'b0;
            evt_ext   <= 1'b0;
            press_cnt <= '0;
            err_ovf   <= 1'b0;
        end else begin
            if (is_code) begin
                ext_flag <= 1'b0;
                brk_flag <= 1'b0;
            end else if (take) begin
                ext_flag <= ext_flag | (ps2_data == 8'hE0);
                brk_flag <= brk_flag | (ps2_data == 8'hF0);
            end
            if (emit) begin
                evt_valid <= 1'b1;
                evt_code  <= ps2_data;
                evt_break <= brk_flag;
                evt_ext   <= ext_flag;
            end else if (evt_ready) begin
                evt_valid <= 1'b0;
            end
            if (emit && !brk_flag)
                press_cnt <= press_cnt + CNT_W'(1);
            // overflow set has priority over a simultaneous clear
            err_ovf <= ps2_overflow | (err_ovf & ~err_clr);
        end
endmodule

// File: tb/tb_ps2_key_sequencer.sv
// tb_ps2_key_sequencer: directed tests with a behavioural ps2_keyboard FIFO in front of the DUT.
module tb_ps2_key_sequencer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ps2_clrn, ps2_nextdata_n;
    logic       ps2_ready = 1'b0;
    logic [7:0] ps2_data = 8'h00;
    logic       ps2_overflow = 1'b0;
    logic       evt_valid, evt_break, evt_ext, err_ovf;
    logic       evt_ready = 1'b0;
    logic       err_clr = 1'b0;
    logic [7:0] evt_code, press_cnt;
    int         checks = 0, errors = 0, lows = 0;
    logic [7:0] q[$];

    always #5 clk = ~clk;

    ps2_key_sequencer #(.CNT_W(8)) dut (
        .clk(clk), .rst(rst), .ps2_clrn(ps2_clrn), .ps2_ready(ps2_ready),
        .ps2_data(ps2_data), .ps2_overflow(ps2_overflow), .ps2_nextdata_n(ps2_nextdata_n),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_code(evt_code),
        .evt_break(evt_break), .evt_ext(evt_ext), .press_cnt(press_cnt),
        .err_ovf(err_ovf), .err_clr(err_clr)
    );

    // keyboard FIFO: pops its head on each clock where nextdata_n is low, flushed while clrn is low
    always @(posedge clk) begin
        if (!ps2_clrn) q.delete();
        else if (!ps2_nextdata_n) begin
            lows++;
            if (q.size() > 0) void'(q.pop_front());
        end
        ps2_ready <= q.size() > 0;
        ps2_data  <= q.size() > 0 ? q[0] : 8'h00;
    end

    task automatic push(input logic [7:0] b);
        q.push_back(b);
    endtask

    task automatic wait_evt(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (evt_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic accept();
        evt_ready = 1'b1;
        @(negedge clk);
        evt_ready = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (ps2_clrn !== 1'b0) begin errors++; $display("FAIL reset_clrn got %b want 0", ps2_clrn); end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (ps2_clrn !== 1'b1 || ps2_nextdata_n !== 1'b1 || evt_valid !== 1'b0 || evt_code !== 8'h00 ||
            evt_break !== 1'b0 || evt_ext !== 1'b0 || press_cnt !== 8'h00 || err_ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got clrn=%b nd=%b v=%b code=%h b=%b e=%b cnt=%h ovf=%b want 1 1 0 00 0 0 00 0",
                     ps2_clrn, ps2_nextdata_n, evt_valid, evt_code, evt_break, evt_ext, press_cnt, err_ovf);
        end
    endtask

    task automatic test_press();
        bit ok;
        int l0 = lows;
        push(8'h1C);
        wait_evt(ok);
        repeat (4) @(negedge clk);
        checks++;
        if (!ok || evt_code !== 8'h1C || evt_break !== 1'b0 || evt_ext !== 1'b0) begin
            errors++;
            $display("FAIL press_evt got ok=%b code=%h b=%b e=%b want 1 1c 0 0", ok, evt_code, evt_break, evt_ext);
        end
        checks++;
        if (press_cnt !== 8'h01) begin errors++; $display("FAIL press_cnt got %h want 01", press_cnt); end
        checks++;
        if (lows - l0 != 1) begin errors++; $display("FAIL press_pops got %0d want 1", lows - l0); end
        accept();
        checks++;
        if (evt_valid !== 1'b0) begin errors++; $display("FAIL press_drop got %b want 0", evt_valid); end
    endtask

    task automatic test_break();
        bit ok;
        int l0 = lows;
        push(8'hF0);
        push(8'h1C);
        wait_evt(ok);
        repeat (4) @(negedge clk);
        checks++;
        if (!ok || evt_code !== 8'h1C || evt_break !== 1'b1 || evt_ext !== 1'b0) begin
            errors++;
            $display("FAIL break_evt got ok=%b code=%h b=%b e=%b want 1 1c 1 0", ok, evt_code, evt_break, evt_ext);
        end
        checks++;
        if (press_cnt !== 8'h01 || lows - l0 != 2) begin
            errors++;
            $display("FAIL break_cnt_pops got cnt=%h pops=%0d want 01 2", press_cnt, lows - l0);
        end
        accept();
    endtask

    task automatic test_extended();
        bit ok;
        push(8'hE0); push(8'hF0); push(8'h75);
        wait_evt(ok);
        checks++;
        if (!ok || evt_code !== 8'h75 || evt_break !== 1'b1 || evt_ext !== 1'b1 || press_cnt !== 8'h01) begin
            errors++;
            $display("FAIL ext_break got ok=%b code=%h b=%b e=%b cnt=%h want 1 75 1 1 01",
                     ok, evt_code, evt_break, evt_ext, press_cnt);
        end
        accept();
        push(8'hE0); push(8'h75);
        wait_evt(ok);
        checks++;
        if (!ok || evt_code !== 8'h75 || evt_break !== 1'b0 || evt_ext !== 1'b1 || press_cnt !== 8'h02) begin
            errors++;
            $display("FAIL ext_press got ok=%b code=%h b=%b e=%b cnt=%h want 1 75 0 1 02",
                     ok, evt_code, evt_break, evt_ext, press_cnt);
        end
        accept();
        push(8'hF0); push(8'hF0); push(8'h1C);
        wait_evt(ok);
        checks++;
        if (!ok || evt_code !== 8'h1C || evt_break !== 1'b1 || evt_ext !== 1'b0 || press_cnt !== 8'h02) begin
            errors++;
            $display("FAIL double_f0 got ok=%b code=%h b=%b e=%b cnt=%h want 1 1c 1 0 02",
                     ok, evt_code, evt_break, evt_ext, press_cnt);
        end
        accept();
    endtask

    task automatic test_backpressure();
        bit ok;
        int l0 = lows;
        evt_ready = 1'b0;
        push(8'h1C); push(8'h32);
        wait_evt(ok);
        repeat (12) @(negedge clk);
        checks++;
        if (!ok || !evt_valid || evt_code !== 8'h1C) begin
            errors++;
            $display("FAIL bp_hold got ok=%b v=%b code=%h want 1 1 1c", ok, evt_valid, evt_code);
        end
        checks++;
        if (lows - l0 != 1 || ps2_nextdata_n !== 1'b1 || q.size() != 1) begin
            errors++;
            $display("FAIL bp_nopop got pops=%0d nd=%b queued=%0d want 1 1 1", lows - l0, ps2_nextdata_n, q.size());
        end
        accept();
        checks++;
        if (evt_valid !== 1'b1 || evt_code !== 8'h32 || evt_break !== 1'b0 || press_cnt !== 8'h04) begin
            errors++;
            $display("FAIL bp_next got v=%b code=%h b=%b cnt=%h want 1 32 0 04", evt_valid, evt_code, evt_break, press_cnt);
        end
        accept();
        checks++;
        if (evt_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got %b want 0", evt_valid); end
    endtask

    task automatic test_wrap_and_ovf();
        evt_ready = 1'b1;
        for (int i = 0; i < 251; i++) push(i[0] ? 8'h34 : 8'h2B);
        for (int i = 0; i < 3000 && q.size() > 0; i++) @(negedge clk);
        repeat (6) @(negedge clk);
        checks++;
        if (press_cnt !== 8'hFF) begin errors++; $display("FAIL cnt_ff got %h want ff", press_cnt); end
        push(8'h24);
        repeat (10) @(negedge clk);
        checks++;
        if (press_cnt !== 8'h00 || evt_code !== 8'h24) begin
            errors++;
            $display("FAIL cnt_wrap got cnt=%h code=%h want 00 24", press_cnt, evt_code);
        end
        evt_ready = 1'b0;
        ps2_overflow = 1'b1;
        @(negedge clk);
        ps2_overflow = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (err_ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b want 1", err_ovf); end
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        checks++;
        if (err_ovf !== 1'b0) begin errors++; $display("FAIL ovf_clr got %b want 0", err_ovf); end
        ps2_overflow = 1'b1;
        err_clr = 1'b1;
        @(negedge clk);
        ps2_overflow = 1'b0;
        err_clr = 1'b0;
        checks++;
        if (err_ovf !== 1'b1) begin errors++; $display("FAIL ovf_set_wins got %b want 1", err_ovf); end
    endtask

    task automatic test_reset_mid_prefix();
        bit ok;
        int l0 = lows;
        push(8'hE0);
        for (int i = 0; i < 60 && lows == l0; i++) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (evt_valid !== 1'b0 || press_cnt !== 8'h00 || err_ovf !== 1'b0) begin
            errors++;
            $display("FAIL mid_rst got v=%b cnt=%h ovf=%b want 0 00 0", evt_valid, press_cnt, err_ovf);
        end
        push(8'h75);
        wait_evt(ok);
        checks++;
        if (!ok || evt_code !== 8'h75 || evt_break !== 1'b0 || evt_ext !== 1'b0 || press_cnt !== 8'h01) begin
            errors++;
            $display("FAIL after_rst got ok=%b code=%h b=%b e=%b cnt=%h want 1 75 0 0 01",
                     ok, evt_code, evt_break, evt_ext, press_cnt);
        end
        accept();
    endtask

    task automatic test_repeat();
        int l0 = lows;
        logic [7:0] want;
`ifdef TYPEMATIC_FILTER_EN
        want = 8'h02;
`else
        want = 8'h04;
`endif
        evt_ready = 1'b1;
        push(8'h1C); push(8'h1C); push(8'h1C);
        repeat (20) @(negedge clk);
        evt_ready = 1'b0;
        checks++;
        if (press_cnt !== want || evt_code !== 8'h1C || lows - l0 != 3) begin
            errors++;
            $display("FAIL repeat got cnt=%h code=%h pops=%0d want %h 1c 3", press_cnt, evt_code, lows - l0, want);
        end
    endtask

    initial begin
        test_reset();
        test_press();
        test_break();
        test_extended();
        test_backpressure();
        test_wrap_and_ovf();
        test_reset_mid_prefix();
        test_repeat();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
